softmax_argmax_seq: RTL and testbench
=====================================

Name: softmax_argmax_seq

Overview:
- Consumer end of the softmax output interface: takes the N-element fixed-point probability vector and reduces it to a class decision.
- Captures one vector through a valid/ready handshake, then scans it one element per cycle.
- Emits the winning class index, its probability, and a confidence flag through a second valid/ready handshake.
- Sits between the softmax layer and the top-level result register / readout logic.

Parameters:
- N, 10, number of classes (N >= 1)
- WIDTH, 16, width of each signed probability word
- NFRAC, 10, fractional bits of each probability word
- CONF_THRESH, 16'sd512, signed threshold in the same Q format (512 = 0.5 at NFRAC=10)
- IDX_W, $clog2(N) (minimum 1), class index width; derived, do not override

Ports:
- clk, input, 1, clock
- reset, input, 1, synchronous active-low reset
- in_valid, input, 1, probability vector valid
- in_ready, output, 1, block can accept a vector
- in_data, input, WIDTH x [N-1:0], signed probabilities (unpacked array)
- out_valid, output, 1, result valid
- out_ready, input, 1, downstream accepts the result
- out_idx, output, IDX_W, argmax class index
- out_max, output, WIDTH, signed probability of the winning class
- out_conf, output, 1, out_max >= CONF_THRESH
- busy, output, 1, high in SCAN or DONE

Behaviour:
- Reset (reset==0 at a posedge): state=IDLE; in_ready=1; out_valid=0; out_idx=0; out_max=0; out_conf=0; busy=0. Reset has priority over every other event. Reset mid-SCAN or mid-DONE aborts the operation and discards the vector.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at the edge: register all N words; best_val=in_data[0]; best_idx=0; scan counter cnt=1. Go to SCAN; if N==1, go directly to DONE.
  - SCAN: in_ready=0. Each cycle compare reg[cnt] against best_val, signed and strictly greater. Update best_val/best_idx on greater; cnt++. On the edge where cnt==N-1 is processed, go to DONE.
  - DONE: out_valid=1, and out_idx/out_max/out_conf stay stable while out_valid=1 && out_ready=0. On out_ready, go to IDLE and drop out_valid.
- Latency:
  - out_valid rises N-1 edges after the accepting edge (N=1: on the edge after acceptance, i.e. out_valid visible the cycle after).
  - Minimum throughput is one vector per N+1 cycles when out_ready is held high.
- Ties: the lowest index wins (strict > comparison).
- Arithmetic:
  - All compares are signed WIDTH-bit. Negative values (possible from a saturated upstream) are handled as ordinary signed numbers.
  - No saturation or rescaling is applied; out_max is the raw registered word.
  - out_conf is computed as a signed compare at DONE entry and registered.
- in_data is sampled only at the accepting edge; changes afterwards are ignored.
- in_valid while busy is held off by in_ready=0, and the upstream must hold its data.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- SOFTMAX_ARGMAX_TOP2_EN defined:
  - Track the second-best value/index as well (second_val initialised to the most negative WIDTH value, second_idx=0).
  - Add output ports out_idx2 (IDX_W) and out_margin (WIDTH+1, signed, = out_max - second_val).
  - out_conf becomes (out_max >= CONF_THRESH) && (out_margin >= CONF_THRESH>>>1).
  - For N==1: out_idx2=0 and out_margin=out_max - most-negative value.
- SOFTMAX_ARGMAX_TOP2_EN not defined: these ports and registers do not exist, and out_conf is threshold-only.

Decomposition:
- Shared package softmax_pkg holds:
  - the state enum typedef (IDLE, SCAN, DONE)
  - the default CONF_THRESH localparam
  - a function clog2_min1(n) for IDX_W
- Sub-module argmax_cmp: a combinational compare/select cell (current best val/idx, candidate val/idx -> new best, plus new second under the macro). Instantiated once inside the scan datapath.

Test Plan:
- N=5, WIDTH=16, NFRAC=10, in_data={0x0100,0x0080,0x0300,0x0040,0x0040} (index 0 first), out_ready=1 -> out_valid 4 edges after accept; out_idx=2; out_max=0x0300; out_conf=1.
- Tie: {0x0200,0x0200,0x0200,0x0000,0x0000} -> out_idx=0; out_max=0x0200; out_conf=1. All zeros -> out_idx=0; out_conf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a new vector -> in_ready stays 0 and outputs stay stable. Release out_ready -> next vector accepted the following cycle and its result is correct.
- Negative inputs: {-0x0010,-0x0400,-0x0008,-0x0200,-0x7FFF} -> out_idx=2; out_max=-0x0008 (0xFFF8); out_conf=0.
- Reset mid-SCAN: assert reset=0 for one edge at cnt=2 -> next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0. A following vector produces the correct result.
- With SOFTMAX_ARGMAX_TOP2_EN, {0x0100,0x0300,0x0280,0,0} -> out_idx=1; out_idx2=2; out_margin=0x0080; out_conf=0 (margin 128 < 256).

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared types, defaults and helpers for the softmax argmax reducer.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // 0.5 in Q5.10
  localparam logic signed [15:0] CONF_THRESH_DEF = 16'sd512;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/softmax_argmax_cmp.sv
// Combinational compare/select cell: folds one candidate into the running best
// (and runner-up when SOFTMAX_ARGMAX_TOP2_EN is defined). Strict > keeps the lowest index on ties.
module argmax_cmp
  import softmax_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic signed [WIDTH-1:0] best_val,
  input  logic        [IDX_W-1:0] best_idx,
  input  logic signed [WIDTH-1:0] cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  input  logic signed [WIDTH-1:0] second_val,
  input  logic        [IDX_W-1:0] second_idx,
  output logic signed [WIDTH-1:0] new_second_val,
  output logic        [IDX_W-1:0] new_second_idx,
`endif
  output logic signed [WIDTH-1:0] new_best_val,
  output logic        [IDX_W-1:0] new_best_idx
);

  always_comb begin
    new_best_val = best_val;
    new_best_idx = best_idx;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    new_second_val = second_val;
    new_second_idx = second_idx;
    if (cand_val > best_val) begin
      new_best_val   = cand_val;
      new_best_idx   = cand_idx;
      // displaced leader becomes the runner-up
      new_second_val = best_val;
      new_second_idx = best_idx;
    end else if (cand_val > second_val) begin
      new_second_val = cand_val;
      new_second_idx = cand_idx;
    end
`else
    if (cand_val > best_val) begin
      new_best_val = cand_val;
      new_best_idx = cand_idx;
    end
`endif
  end

endmodule

// File: rtl/softmax_argmax_seq.sv
// Captures an N-word probability vector, scans it one word per cycle and hands off the
// argmax class, its value and a confidence flag. SOFTMAX_ARGMAX_TOP2_EN adds runner-up tracking.
//
// state | meaning
// IDLE  | in_ready high, waiting for a vector
// SCAN  | comparing vec[cnt] against the running best, one word per cycle
// DONE  | result presented with out_valid, held until out_ready
module softmax_argmax_seq
  import softmax_pkg::*;
#(
  parameter int N = 10,
  parameter int WIDTH = 16,
  parameter int NFRAC = 10,
  parameter logic signed [WIDTH-1:0] CONF_THRESH = WIDTH'(CONF_THRESH_DEF),
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data [N-1:0],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [IDX_W-1:0] out_idx,
  output logic signed [WIDTH-1:0] out_max,
  output logic                    out_conf,
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  output logic        [IDX_W-1:0] out_idx2,
  output logic signed [WIDTH:0]   out_margin,
`endif
  output logic                    busy
);

  if (N < 1 || NFRAC >= WIDTH) begin : g_param_check
    $error("softmax_argmax_seq: N must be >= 1 and NFRAC < WIDTH");
  end

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0] state;
  logic signed [WIDTH-1:0] vec [N-1:0];
  logic signed [WIDTH-1:0] best_val, nb_val, fin_val;
  logic [IDX_W-1:0] best_idx, nb_idx, fin_idx, cnt;
  logic accept, load_res, fin_conf;

`ifdef SOFTMAX_ARGMAX_TOP2_EN
  localparam logic signed [WIDTH:0] MARGIN_THRESH = (WIDTH+1)'(CONF_THRESH >>> 1);
  logic signed [WIDTH-1:0] second_val, ns_val, fin_sec_val;
  logic [IDX_W-1:0] second_idx, ns_idx, fin_sec_idx;
  logic signed [WIDTH:0] fin_margin;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_ready && in_valid;
  // a single-class vector needs no scan: its result is loaded at the accepting edge
  assign load_res  = (N == 1) ? accept : ((state == ST_SCAN) && (cnt == LAST));

  argmax_cmp #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_cmp (
    .best_val       (best_val),
    .best_idx       (best_idx),
    .cand_val       (vec[cnt]),
    .cand_idx       (cnt),
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    .second_val     (second_val),
    .second_idx     (second_idx),
    .new_second_val (ns_val),
    .new_second_idx (ns_idx),
`endif
    .new_best_val   (nb_val),
    .new_best_idx   (nb_idx)
  );

  always_comb begin
    fin_val = nb_val;
    fin_idx = nb_idx;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    fin_sec_val = ns_val;
    fin_sec_idx = ns_idx;
`endif
    if (N == 1) begin
      fin_val = in_data[0];
      fin_idx = '0;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      fin_sec_val = MOST_NEG;
      fin_sec_idx = '0;
`endif
    end
  end

`ifdef SOFTMAX_ARGMAX_TOP2_EN
  assign fin_margin = {fin_val[WIDTH-1], fin_val} - {fin_sec_val[WIDTH-1], fin_sec_val};
  assign fin_conf   = (fin_val >= CONF_THRESH) && (fin_margin >= MARGIN_THRESH);
`else
  assign fin_conf   = (fin_val >= CONF_THRESH);
`endif

  always_ff @(posedge clk) begin
    if (reset && accept) vec <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      best_val <= '0;
      best_idx <= '0;
      cnt      <= '0;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      second_val <= MOST_NEG;
      second_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            best_val <= in_data[0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
`ifdef SOFTMAX_ARGMAX_TOP2_EN
            second_val <= MOST_NEG;
            second_idx <= '0;
`endif
            state <= (N == 1) ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_val <= nb_val;
          best_idx <= nb_idx;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
          second_val <= ns_val;
          second_idx <= ns_idx;
`endif
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_idx  <= '0;
      out_max  <= '0;
      out_conf <= 1'b0;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      out_idx2   <= '0;
      out_margin <= '0;
`endif
    end else if (load_res) begin
      out_idx  <= fin_idx;
      out_max  <= fin_val;
      out_conf <= fin_conf;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      out_idx2   <= fin_sec_idx;
      out_margin <= fin_margin;
`endif
    end
  end

endmodule

// File: tb/tb_softmax_argmax_seq.sv
// Scoreboard bench for softmax_argmax_seq with N=5: expected results are queued at
// acceptance and compared when the result handshake fires.
module tb_softmax_argmax_seq;

  localparam int N = 5;
  localparam int W = 16;

  typedef logic signed [W-1:0] vec_t [N-1:0];
  typedef struct {
    logic [31:0] idx;
    logic [31:0] max;
    logic [31:0] conf;
    logic [31:0] idx2;
    logic [31:0] margin;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  vec_t in_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2:0] out_idx;
  logic signed [W-1:0] out_max;
  logic out_conf;
  logic busy;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [2:0] out_idx2;
  logic signed [W:0] out_margin;
`endif

  int total = 0;
  int bad = 0;
  int n_sent = 0;
  int n_out = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  softmax_argmax_seq #(.N(N), .WIDTH(W), .NFRAC(10), .CONF_THRESH(16'sd512)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_max    (out_max),
    .out_conf   (out_conf),
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    .out_idx2   (out_idx2),
    .out_margin (out_margin),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3, input int a4);
    vec_t v;
    v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3); v[4] = 16'(a4);
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int b = 0;
    int s = -1;
    int m;
    for (int i = 1; i < N; i++) if (v[i] > v[b]) b = i;
    for (int i = 0; i < N; i++) if (i != b && (s < 0 || v[i] > v[s])) s = i;
    m = int'(v[b]) - int'(v[s]);
    e.idx  = 32'(b);
    e.max  = {16'h0, v[b]};
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    e.conf = {31'h0, (v[b] >= 16'sd512) && (m >= 256)};
`else
    e.conf = {31'h0, v[b] >= 16'sd512};
`endif
    e.idx2   = 32'(s);
    e.margin = {15'h0, 17'(m)};
    return e;
  endfunction

  task automatic send(input vec_t v, output int waits);
    in_data  = v;
    in_valid = 1'b1;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (in_ready !== 1'b1 && waits < 100);
    if (in_ready !== 1'b1) chk("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      sb.push_back(model(v));
      n_sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // result monitor: a handshake completes at the posedge following a negedge with valid&&ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (sb.size() == 0) chk("spurious_result", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("out_idx", 32'(out_idx), e.idx);
          chk("out_max", {16'h0, out_max}, e.max);
          chk("out_conf", 32'(out_conf), e.conf);
`ifdef SOFTMAX_ARGMAX_TOP2_EN
          chk("out_idx2", 32'(out_idx2), e.idx2);
          chk("out_margin", {15'h0, out_margin}, e.margin);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, edges;
    vec_t x, y;
    exp_t ex;
    in_data = mk(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_max", {16'h0, out_max}, 32'd0);
    chk("rst_out_conf", 32'(out_conf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // basic vector, latency of N-1 edges after accept
    send(mk('h0100, 'h0080, 'h0300, 'h0040, 'h0040), w);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_scan", 32'(in_ready), 32'd0);
    wait_out_valid(edges);
    chk("latency", 32'(edges), 32'(N - 1));
    drain();

    send(mk('h0200, 'h0200, 'h0200, 'h0000, 'h0000), w);
    drain();
    send(mk(0, 0, 0, 0, 0), w);
    drain();
    send(mk(-'h0010, -'h0400, -'h0008, -'h0200, -'h7FFF), w);
    drain();

    // back-to-back throughput with out_ready held high
    send(mk('h0010, 'h0020, 'h0030, 'h0040, 'h0050), w);
    send(mk('h0400, 'h0010, 'h0020, 'h0030, 'h0040), w);
    chk("throughput_cycles", 32'(w), 32'(N + 1));
    drain();

    // backpressure in DONE while a new vector waits
    out_ready = 1'b0;
    x = mk('h0050, 'h0070, 'h0060, 'h0250, 'h0010);
    y = mk('h0010, 'h0020, 'h0500, 'h0030, 'h0040);
    ex = model(x);
    send(x, w);
    wait_out_valid(edges);
    in_data  = y;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_idx", 32'(out_idx), ex.idx);
      chk("bp_out_max", {16'h0, out_max}, ex.max);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_release", 32'(in_ready), 32'd1);
    sb.push_back(model(y));
    n_sent++;
    @(posedge clk); #1;
    chk("bp_next_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    drain();

    // reset while cnt==2 aborts and clears everything
    send(mk('h0300, 'h0100, 'h0200, 'h0700, 'h0000), w);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    void'(sb.pop_back());
    n_sent--;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_out_max", {16'h0, out_max}, 32'd0);
    chk("mid_rst_out_conf", 32'(out_conf), 32'd0);
    send(mk('h0020, 'h0010, 'h0030, 'h0280, 'h0270), w);
    drain();

`ifdef SOFTMAX_ARGMAX_TOP2_EN
    send(mk('h0100, 'h0300, 'h0280, 0, 0), w);
    drain();
`endif

    // random vectors: wide range, then coarse values to force ties
    for (int r = 0; r < 8; r++) begin
      vec_t v;
      for (int i = 0; i < N; i++) begin
        if (r < 4) v[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
        else v[i] = 16'(int'($urandom_range(0, 3)) * 256 - 256);
      end
      send(v, w);
      if (r[0]) drain();
    end
    drain();

    chk("results_seen", 32'(n_out), 32'(n_sent));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
